// File: rtl/sound_latch_ctrl.sv
// ----------------------------------------------------------------------------
// sound_latch_ctrl
//
// Purpose:
//   Glue between the 68k main CPU and the Z80 sound CPU. Holds the one-byte
//   sound latch the 68k writes and the Z80 reads/clears. Also holds the Z80
//   audio ROM bank register. Generates a periodic Z80 IRQ request with
//   hold-line semantics that is cleared by the Z80 interrupt acknowledge
//   cycle.
//
// Optional feature (macro SOUND_LATCH_NMI_EN):
//   When defined, a latch write pulls z80_nmi_n low. The NMI is released by
//   the Z80 reading the latch (z80_latch_cs edge) or by clearing it. When
//   undefined, z80_nmi_n is tied high and no NMI state exists.
//
// Ports:
//   clk               in   system clock, all state changes on rising edge
//   reset             in   synchronous, active-high reset
//   m68k_latch_cs     in   68k latch write select (level, multi-cycle)
//   m68k_din[7:0]     in   68k data bus low byte
//   z80_latch_cs      in   Z80 latch read select (level)
//   z80_latch_clr_cs  in   Z80 latch clear select (level)
//   z80_bank_set_cs   in   Z80 bank register write select (level)
//   z80_din[7:0]      in   Z80 data-out bus
//   M1_n              in   Z80 M1, active low
//   IORQ_n            in   Z80 IORQ, active low
//   latch_dout[7:0]   out  current latch contents
//   latch_pending     out  latch written and not yet cleared
//   z80_bank[4:0]     out  audio ROM bank for the C000-FFFF window
//   z80_irq_n         out  Z80 INT, active low (held until acknowledged)
//   z80_nmi_n         out  Z80 NMI, active low
// ----------------------------------------------------------------------------
module sound_latch_ctrl #(
    parameter int IRQ_DIV = 1050
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       m68k_latch_cs,
    input  logic [7:0] m68k_din,
    input  logic       z80_latch_cs,
    input  logic       z80_latch_clr_cs,
    input  logic       z80_bank_set_cs,
    input  logic [7:0] z80_din,
    input  logic       M1_n,
    input  logic       IORQ_n,
    output logic [7:0] latch_dout,
    output logic       latch_pending,
    output logic [4:0] z80_bank,
    output logic       z80_irq_n,
    output logic       z80_nmi_n
);

    localparam int CNT_W = (IRQ_DIV > 1) ? $clog2(IRQ_DIV) : 1;
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(IRQ_DIV - 1);

    // Select vector bit positions
    localparam int SEL_WR  = 0;  // 68k latch write
    localparam int SEL_CLR = 1;  // Z80 latch clear
    localparam int SEL_BNK = 2;  // Z80 bank set
    localparam int SEL_RD  = 3;  // Z80 latch read (only meaningful with NMI)
    localparam int SEL_ACK = 4;  // Z80 interrupt acknowledge

    logic             w_ack_lvl;
    logic             w_rd_lvl;
    logic [4:0]       w_sel;
    logic [4:0]       w_edge;
    logic             w_wrap;
    logic             w_unused;

    logic [4:0]       r_sel_q;
    logic [4:0]       r_hold;
    logic [7:0]       r_latch;
    logic             r_pending;
    logic [4:0]       r_bank;
    logic [CNT_W-1:0] r_div;
    logic             r_irq_n;

    assign w_ack_lvl = ~M1_n & ~IORQ_n;

`ifdef SOUND_LATCH_NMI_EN
    assign w_rd_lvl = z80_latch_cs;
    assign w_unused = &{1'b0, z80_din[7:5]};
`else
    // The read select has no effect without the NMI feature.
    assign w_rd_lvl = 1'b0;
    assign w_unused = &{1'b0, z80_din[7:5], z80_latch_cs, w_edge[SEL_RD]};
`endif

    assign w_sel = {w_ack_lvl, w_rd_lvl, z80_bank_set_cs, z80_latch_clr_cs, m68k_latch_cs};

    // r_hold masks selects that were already high while reset was asserted,
    // so releasing reset in the middle of an assertion is not seen as an edge.
    // It clears as soon as the select drops.
    assign w_edge = w_sel & ~r_sel_q & ~r_hold;

    assign w_wrap = (r_div == DIV_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sel_q   <= '0;
            r_hold    <= w_sel;
            r_latch   <= 8'h00;
            r_pending <= 1'b0;
            r_bank    <= 5'd0;
            r_div     <= '0;
            r_irq_n   <= 1'b1;
        end else begin
            r_sel_q <= w_sel;
            r_hold  <= r_hold & w_sel;

            r_div <= w_wrap ? '0 : r_div + 1'b1;

            // A wrap wins over an acknowledge so no request is lost.
            if (w_wrap) begin
                r_irq_n <= 1'b0;
            end else if (w_edge[SEL_ACK]) begin
                r_irq_n <= 1'b1;
            end

            // A 68k write beats a simultaneous clear.
            if (w_edge[SEL_WR]) begin
                r_latch   <= m68k_din;
                r_pending <= 1'b1;
            end else if (w_edge[SEL_CLR]) begin
                r_latch   <= 8'h00;
                r_pending <= 1'b0;
            end

            if (w_edge[SEL_BNK]) begin
                r_bank <= z80_din[4:0];
            end
        end
    end

`ifdef SOUND_LATCH_NMI_EN
    logic r_nmi_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_nmi_n <= 1'b1;
        end else if (w_edge[SEL_WR]) begin
            r_nmi_n <= 1'b0;
        end else if (w_edge[SEL_RD] || w_edge[SEL_CLR]) begin
            r_nmi_n <= 1'b1;
        end
    end

    assign z80_nmi_n = r_nmi_n;
`else
    assign z80_nmi_n = 1'b1;
`endif

    assign latch_dout    = r_latch;
    assign latch_pending = r_pending;
    assign z80_bank      = r_bank;
    assign z80_irq_n     = r_irq_n;

endmodule

// File: tb/tb_sound_latch_ctrl.sv
module tb_sound_latch_ctrl;

    localparam int DIV = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       m68k_latch_cs = 1'b0;
    logic [7:0] m68k_din = 8'h00;
    logic       z80_latch_cs = 1'b0;
    logic       z80_latch_clr_cs = 1'b0;
    logic       z80_bank_set_cs = 1'b0;
    logic [7:0] z80_din = 8'h00;
    logic       M1_n = 1'b1;
    logic       IORQ_n = 1'b1;
    logic [7:0] latch_dout;
    logic       latch_pending;
    logic [4:0] z80_bank;
    logic       z80_irq_n;
    logic       z80_nmi_n;

    int checks = 0;
    int errors = 0;

    sound_latch_ctrl #(.IRQ_DIV(DIV)) dut (
        .clk(clk),
        .reset(reset),
        .m68k_latch_cs(m68k_latch_cs),
        .m68k_din(m68k_din),
        .z80_latch_cs(z80_latch_cs),
        .z80_latch_clr_cs(z80_latch_clr_cs),
        .z80_bank_set_cs(z80_bank_set_cs),
        .z80_din(z80_din),
        .M1_n(M1_n),
        .IORQ_n(IORQ_n),
        .latch_dout(latch_dout),
        .latch_pending(latch_pending),
        .z80_bank(z80_bank),
        .z80_irq_n(z80_irq_n),
        .z80_nmi_n(z80_nmi_n)
    );

    always #5 clk = ~clk;

`ifdef SOUND_LATCH_NMI_EN
    localparam bit NMI_EN = 1'b1;
`else
    localparam bit NMI_EN = 1'b0;
`endif

    // Reference model: state as the spec describes it. A select "fires" when
    // it is high and was low on the previous sampled cycle; after reset only
    // selects seen low during reset may fire. The IRQ request is set whenever
    // the number of cycles since reset release is a multiple of DIV.
    logic [7:0] m_latch = 8'h00;
    logic       m_pend = 1'b0;
    logic [4:0] m_bank = 5'd0;
    logic       m_req = 1'b0;
    logic       m_nmi_n = 1'b1;
    int         m_cyc = 0;
    logic [4:0] m_armed = 5'b0;
    bit         m_valid = 1'b0;

    always @(posedge clk) begin : model
        logic [4:0] lvl;
        logic [4:0] fire;
        lvl = {~M1_n & ~IORQ_n, z80_latch_cs, z80_bank_set_cs, z80_latch_clr_cs, m68k_latch_cs};
        if (reset) begin
            m_latch = 8'h00;
            m_pend  = 1'b0;
            m_bank  = 5'd0;
            m_req   = 1'b0;
            m_nmi_n = 1'b1;
            m_cyc   = 0;
            m_armed = ~lvl;
            m_valid = 1'b1;
        end else begin
            fire    = lvl & m_armed;
            m_armed = ~lvl;
            m_cyc   = m_cyc + 1;
            if ((m_cyc % DIV) == 0) m_req = 1'b1;
            else if (fire[4])       m_req = 1'b0;
            if (fire[0]) begin
                m_latch = m68k_din;
                m_pend  = 1'b1;
            end else if (fire[1]) begin
                m_latch = 8'h00;
                m_pend  = 1'b0;
            end
            if (fire[2]) m_bank = z80_din[4:0];
            if (NMI_EN) begin
                if (fire[0])                m_nmi_n = 1'b0;
                else if (fire[3] || fire[1]) m_nmi_n = 1'b1;
            end
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            check("model latch_dout", latch_dout, m_latch);
            check("model latch_pending", {7'b0, latch_pending}, {7'b0, m_pend});
            check("model z80_bank", {3'b0, z80_bank}, {3'b0, m_bank});
            check("model z80_irq_n", {7'b0, z80_irq_n}, {7'b0, !m_req});
            check("model z80_nmi_n", {7'b0, z80_nmi_n}, {7'b0, m_nmi_n});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        check("rst latch", latch_dout, 8'h00);
        check("rst pending", {7'b0, latch_pending}, 8'h00);
        check("rst bank", {3'b0, z80_bank}, 8'h00);
        check("rst irq_n", {7'b0, z80_irq_n}, 8'h01);
        check("rst nmi_n", {7'b0, z80_nmi_n}, 8'h01);
        reset = 1'b0;

        // IRQ timing: falls on the 8th cycle after release
        repeat (7) tick();
        check("irq before wrap", {7'b0, z80_irq_n}, 8'h01);
        tick();
        check("irq at wrap", {7'b0, z80_irq_n}, 8'h00);
        M1_n = 1'b0; IORQ_n = 1'b0;
        tick();
        check("irq after ack", {7'b0, z80_irq_n}, 8'h01);
        M1_n = 1'b1; IORQ_n = 1'b1;
        repeat (6) tick();
        check("irq idle", {7'b0, z80_irq_n}, 8'h01);
        M1_n = 1'b0; IORQ_n = 1'b0;
        tick();
        check("irq wrap with ack", {7'b0, z80_irq_n}, 8'h00);
        M1_n = 1'b1; IORQ_n = 1'b1;
        tick();

        // Multi-cycle 68k write captures once
        m68k_din = 8'h5A; m68k_latch_cs = 1'b1;
        tick();
        check("wr latch", latch_dout, 8'h5A);
        check("wr pending", {7'b0, latch_pending}, 8'h01);
        check("wr nmi_n", {7'b0, z80_nmi_n}, NMI_EN ? 8'h00 : 8'h01);
        m68k_din = 8'h11;
        repeat (3) tick();
        check("wr single capture", latch_dout, 8'h5A);
        m68k_latch_cs = 1'b0;
        tick();

        // Z80 read releases NMI, latch unaffected
        z80_latch_cs = 1'b1;
        tick();
        check("rd nmi_n", {7'b0, z80_nmi_n}, 8'h01);
        check("rd latch", latch_dout, 8'h5A);
        z80_latch_cs = 1'b0;

        // Clear
        z80_latch_clr_cs = 1'b1;
        tick();
        check("clr latch", latch_dout, 8'h00);
        check("clr pending", {7'b0, latch_pending}, 8'h00);
        z80_latch_clr_cs = 1'b0;
        tick();

        // Simultaneous write and clear: write wins
        z80_latch_clr_cs = 1'b1; m68k_latch_cs = 1'b1; m68k_din = 8'h33;
        tick();
        check("wr+clr latch", latch_dout, 8'h33);
        check("wr+clr pending", {7'b0, latch_pending}, 8'h01);
        z80_latch_clr_cs = 1'b0; m68k_latch_cs = 1'b0;
        tick();

        // Bank register
        z80_din = 8'hFF; z80_bank_set_cs = 1'b1;
        tick();
        check("bank load", {3'b0, z80_bank}, 8'h1F);
        z80_bank_set_cs = 1'b0;
        tick();

        // Reset mid-assertion: no action on release while selects stay high
        z80_din = 8'h0A; z80_bank_set_cs = 1'b1;
        m68k_din = 8'h77; m68k_latch_cs = 1'b1;
        reset = 1'b1;
        tick();
        check("mid rst bank", {3'b0, z80_bank}, 8'h00);
        check("mid rst latch", latch_dout, 8'h00);
        check("mid rst irq_n", {7'b0, z80_irq_n}, 8'h01);
        reset = 1'b0;
        repeat (3) tick();
        check("post rst bank", {3'b0, z80_bank}, 8'h00);
        check("post rst latch", latch_dout, 8'h00);
        z80_bank_set_cs = 1'b0; m68k_latch_cs = 1'b0;
        tick();

        // Randomized traffic, checked cycle by cycle against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 20) m68k_latch_cs = ~m68k_latch_cs;
            if ($urandom_range(0, 99) < 15) z80_latch_cs = ~z80_latch_cs;
            if ($urandom_range(0, 99) < 15) z80_latch_clr_cs = ~z80_latch_clr_cs;
            if ($urandom_range(0, 99) < 15) z80_bank_set_cs = ~z80_bank_set_cs;
            if ($urandom_range(0, 99) < 25) M1_n = ~M1_n;
            if ($urandom_range(0, 99) < 25) IORQ_n = ~IORQ_n;
            m68k_din = 8'($urandom);
            z80_din  = 8'($urandom);
            reset    = ($urandom_range(0, 149) == 0);
            tick();
        end
        reset = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
